phase_gen: RTL and testbench
============================

# phase_gen

Parametrised multi-phase strobe generator for the capture front end. It derives PHASES non-overlapping or adjacent-overlapping phase strobes from the sample clock, with a programmable per-phase dwell. It supports a clean stop at a rotation boundary and reports wrap/busy status to the sampling controller. With PHASES=4, div=0 and mode=0 it is a drop-in replacement for the existing 4-phase one-hot rotator.

## Interface
- PHASES, 4, number of output phases; legal 2..16
- IDX_W, 2, width of phase_idx; 2^IDX_W >= PHASES required
- DIV_W, 8, width of dwell divider input
- CLKin  input  1  sample clock; all logic on posedge
- RSTin  input  1  reset, synchronous and active-high; overrides every other input
- start  input  1  run request; level-sensitive
- div  input  DIV_W  dwell per phase minus one (phase lasts div+1 cycles)
- mode  input  1  0 = one-hot, 1 = adjacent two-hot overlap
- CLKout  output  PHASES  registered phase strobes
- phase_idx  output  IDX_W  registered index of current phase
- wrap  output  1  one-cycle pulse on return to phase 0 or on drain completion
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, RUN, DRAIN. Internal dwell counter cnt (DIV_W bits), latched copies div_l and mode_l.
- Reset / IDLE values: CLKout=0, phase_idx=0, cnt=0, wrap=0, busy=0, div_l=0, mode_l=0.
- IDLE, start=1 → RUN. Latch div_l=div and mode_l=mode, set phase_idx=0 and cnt=0, and drive the pattern for phase 0.
- Pattern, registered with phase_idx:
  - mode_l=0: CLKout = 1<<idx.
  - mode_l=1: CLKout = (1<<idx) | (1<<((idx+1) mod PHASES)).
- RUN, cnt<div_l: cnt+1, outputs hold.
- RUN, cnt==div_l (phase boundary): cnt=0 and idx=(idx+1) mod PHASES.
  - If the old idx==PHASES-1, relatch div_l/mode_l and pulse wrap with the new phase-0 pattern.
  - div/mode changes take effect only at wrap or at RUN entry.
- start=0 in RUN: behaviour per Configuration.
- DRAIN: counts and rotates exactly as RUN.
  - At the boundary that ends phase PHASES-1: go to IDLE with CLKout=0, phase_idx=0, wrap=1 for that cycle.
  - If start=1 is sampled in DRAIN, return to RUN with no change to rotation.
- div=0: phase advances every cycle. div=all-ones: dwell is 2^DIV_W cycles; cnt never overflows.
- Simultaneous events:
  - start=1 re-sampled on the drain-final boundary: go to IDLE; a new run begins on the following cycle.
  - RSTin asserted mid-rotation or in DRAIN: IDLE values on the next edge, no wrap.

## Timing
- Start latency: start sampled high in IDLE at edge N → CLKout=phase-0 pattern after edge N, busy high after edge N.
- Each phase is exactly div_l+1 cycles. A full rotation is PHASES×(div_l+1) cycles.
- wrap is high for exactly one cycle, aligned with the first cycle of phase 0 (or the first IDLE cycle after drain).
- All outputs are registered, with no combinational path from inputs to outputs.
- Immediate-stop latency (macro off): start sampled low at edge N → IDLE values after edge N.

## Configuration
- PHASE_GEN_GRACEFUL_STOP_EN defined: start=0 in RUN enters DRAIN, and the current rotation completes through phase PHASES-1 before stopping.
- Not defined: start=0 in RUN or DRAIN goes to IDLE on that edge with CLKout=0 and phase_idx=0 (legacy abrupt stop). The DRAIN state is not built.

## Test plan
- PHASES=4, div=0, mode=0, start held high: CLKout sequence 1,2,4,8,1…; wrap pulses every 4 cycles with CLKout=1.
- PHASES=6, div=2, mode=1: each pattern lasts 3 cycles: 0x03,0x06,0x0C,0x18,0x30,0x21; wrap every 18 cycles.
- div changed 0→3 mid-rotation: dwell stays 1 cycle until the next wrap, then becomes 4 cycles.
- Graceful stop (macro on), PHASES=4, div=1: start dropped while idx=1. Rotation continues through idx=3, then CLKout=0, busy=0, wrap=1. Repeat with start re-raised during DRAIN: rotation never stops.
- Macro off: start dropped while idx=2 → next cycle CLKout=0, phase_idx=0, busy=0, no wrap.
- RSTin asserted at idx=3 mid-dwell with start high: next cycle all outputs at reset values. Deassert → phase-0 pattern one cycle later.

Source files
------------

// File: rtl/phase_gen_if.sv
// Control/status bundle between the sampling controller (master) and phase_gen (slave).
interface phase_gen_if #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned DIV_W  = 8
);
    logic              start;
    logic [DIV_W-1:0]  div;
    logic              mode;
    logic [PHASES-1:0] CLKout;
    logic [IDX_W-1:0]  phase_idx;
    logic              wrap;
    logic              busy;

    modport master (output start, div, mode, input CLKout, phase_idx, wrap, busy);
    modport slave  (input start, div, mode, output CLKout, phase_idx, wrap, busy);
endinterface

// File: rtl/phase_gen.sv
// Multi-phase strobe generator with per-phase dwell and one-hot / two-hot patterns.
// Optional PHASE_GEN_GRACEFUL_STOP_EN: dropping start finishes the rotation via DRAIN.
module phase_gen #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned DIV_W  = 8
) (
    input  logic CLKin,
    input  logic RSTin,
    phase_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_l;
    logic              mode_l;
    logic [IDX_W-1:0]  idx_q;
    logic [PHASES-1:0] clk_out_q;
    logic              wrap_q;
    logic              busy_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(PHASES - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [PHASES-1:0] pattern(input logic [IDX_W-1:0] i, input logic m);
        logic [PHASES-1:0] p;
        p = PHASES'(1) << i;
        if (m) p = p | (PHASES'(1) << next_idx(i));
        return p;
    endfunction

    logic [IDX_W-1:0] nidx;
    logic             last;
    logic             boundary;

    assign nidx     = next_idx(idx_q);
    assign last     = (idx_q == IDX_W'(PHASES - 1));
    assign boundary = (cnt == div_l);

    always_ff @(posedge CLKin) begin
        if (RSTin) begin
            state     <= IDLE;
            cnt       <= '0;
            div_l     <= '0;
            mode_l    <= 1'b0;
            idx_q     <= '0;
            clk_out_q <= '0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        div_l     <= bus.div;
                        mode_l    <= bus.mode;
                        idx_q     <= '0;
                        cnt       <= '0;
                        clk_out_q <= pattern('0, bus.mode);
                        busy_q    <= 1'b1;
                    end
                end
`ifdef PHASE_GEN_GRACEFUL_STOP_EN
                RUN, DRAIN: begin
                    if (!boundary) begin
                        cnt   <= cnt + DIV_W'(1);
                        state <= bus.start ? RUN : DRAIN;
                    end else if (last && (state == DRAIN || !bus.start)) begin
                        // drain-final boundary wins even if start was re-raised
                        state     <= IDLE;
                        cnt       <= '0;
                        div_l     <= '0;
                        mode_l    <= 1'b0;
                        idx_q     <= '0;
                        clk_out_q <= '0;
                        busy_q    <= 1'b0;
                        wrap_q    <= 1'b1;
                    end else begin
                        state <= bus.start ? RUN : DRAIN;
                        cnt   <= '0;
                        idx_q <= nidx;
                        if (last) begin
                            div_l     <= bus.div;
                            mode_l    <= bus.mode;
                            wrap_q    <= 1'b1;
                            clk_out_q <= pattern('0, bus.mode);
                        end else begin
                            clk_out_q <= pattern(nidx, mode_l);
                        end
                    end
                end
`else
                RUN: begin
                    if (!bus.start) begin
                        // abrupt stop: back to idle values, no wrap
                        state     <= IDLE;
                        cnt       <= '0;
                        div_l     <= '0;
                        mode_l    <= 1'b0;
                        idx_q     <= '0;
                        clk_out_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (!boundary) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt   <= '0;
                        idx_q <= nidx;
                        if (last) begin
                            div_l     <= bus.div;
                            mode_l    <= bus.mode;
                            wrap_q    <= 1'b1;
                            clk_out_q <= pattern('0, bus.mode);
                        end else begin
                            clk_out_q <= pattern(nidx, mode_l);
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    idx_q     <= '0;
                    clk_out_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CLKout    = clk_out_q;
    assign bus.phase_idx = idx_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: 4-phase and 6-phase instances sharing clock and reset.
module tb_phase_gen;

    logic clk;
    logic rst;

    phase_gen_if #(.PHASES(4), .IDX_W(2), .DIV_W(8)) bus4 ();
    phase_gen_if #(.PHASES(6), .IDX_W(3), .DIV_W(8)) bus6 ();

    phase_gen #(.PHASES(4), .IDX_W(2), .DIV_W(8)) dut4 (.CLKin(clk), .RSTin(rst), .bus(bus4));
    phase_gen #(.PHASES(6), .IDX_W(3), .DIV_W(8)) dut6 (.CLKin(clk), .RSTin(rst), .bus(bus6));

    int errors = 0;
    int checks = 0;

    logic [5:0] tbl6 [6] = '{6'h03, 6'h06, 6'h0C, 6'h18, 6'h30, 6'h21};
    int         seq_idx  [11] = '{2, 3, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    int         seq_wrap [11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus4.start = 1'b0;
        bus6.start = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        bus4.start = 1'b0;
        bus4.div   = 8'd0;
        bus4.mode  = 1'b0;
        bus6.start = 1'b0;
        bus6.div   = 8'd0;
        bus6.mode  = 1'b0;

        // reset state
        do_reset();
        check("rst_clkout", 32'(bus4.CLKout), 32'h0);
        check("rst_idx",    32'(bus4.phase_idx), 32'h0);
        check("rst_busy",   32'(bus4.busy), 32'h0);
        check("rst_wrap",   32'(bus4.wrap), 32'h0);

        // 4-phase one-hot, div=0
        bus4.start = 1'b1;
        step();
        check("start_clkout", 32'(bus4.CLKout), 32'h1);
        check("start_busy",   32'(bus4.busy), 32'h1);
        check("start_wrap",   32'(bus4.wrap), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("rot4_clkout", 32'(bus4.CLKout), 32'h1 << (k % 4));
            check("rot4_wrap",   32'(bus4.wrap), ((k % 4) == 0) ? 32'h1 : 32'h0);
        end

        // div change mid-rotation only applies after the next wrap
        step();
        check("divchg_pre_idx", 32'(bus4.phase_idx), 32'h1);
        bus4.div = 8'd3;
        for (int k = 0; k < 11; k++) begin
            step();
            check("divchg_idx",  32'(bus4.phase_idx), 32'(seq_idx[k]));
            check("divchg_wrap", 32'(bus4.wrap), 32'(seq_wrap[k]));
        end

`ifdef PHASE_GEN_GRACEFUL_STOP_EN
        do_reset();
        bus4.div   = 8'd1;
        bus4.start = 1'b1;
        step();
        step();
        step();
        check("gs_idx1", 32'(bus4.phase_idx), 32'h1);
        bus4.start = 1'b0;
        step(); check("gs_a_idx", 32'(bus4.phase_idx), 32'h1);
        step(); check("gs_b_idx", 32'(bus4.phase_idx), 32'h2);
        step(); check("gs_c_idx", 32'(bus4.phase_idx), 32'h2);
        step(); check("gs_d_idx", 32'(bus4.phase_idx), 32'h3);
        step(); check("gs_e_idx", 32'(bus4.phase_idx), 32'h3);
        check("gs_e_busy", 32'(bus4.busy), 32'h1);
        step();
        check("gs_end_clkout", 32'(bus4.CLKout), 32'h0);
        check("gs_end_busy",   32'(bus4.busy), 32'h0);
        check("gs_end_wrap",   32'(bus4.wrap), 32'h1);
        step();
        check("gs_idle_wrap",  32'(bus4.wrap), 32'h0);

        do_reset();
        bus4.start = 1'b1;
        step();
        step();
        step();
        bus4.start = 1'b0;
        step();
        step();
        check("gs_rr_idx2", 32'(bus4.phase_idx), 32'h2);
        bus4.start = 1'b1;
        step(); check("gs_rr_a_idx", 32'(bus4.phase_idx), 32'h2);
        step(); check("gs_rr_b_idx", 32'(bus4.phase_idx), 32'h3);
        step(); check("gs_rr_c_idx", 32'(bus4.phase_idx), 32'h3);
        step();
        check("gs_rr_wrap",   32'(bus4.wrap), 32'h1);
        check("gs_rr_busy",   32'(bus4.busy), 32'h1);
        check("gs_rr_clkout", 32'(bus4.CLKout), 32'h1);
`else
        // abrupt stop at idx=2
        bus4.start = 1'b0;
        step();
        check("stop_clkout", 32'(bus4.CLKout), 32'h0);
        check("stop_idx",    32'(bus4.phase_idx), 32'h0);
        check("stop_busy",   32'(bus4.busy), 32'h0);
        check("stop_wrap",   32'(bus4.wrap), 32'h0);
`endif

        // reset mid-dwell at idx=3
        do_reset();
        bus4.div   = 8'd3;
        bus4.mode  = 1'b0;
        bus4.start = 1'b1;
        step();
        repeat (13) step();
        check("mid_idx3", 32'(bus4.phase_idx), 32'h3);
        rst = 1'b1;
        step();
        check("midrst_clkout", 32'(bus4.CLKout), 32'h0);
        check("midrst_idx",    32'(bus4.phase_idx), 32'h0);
        check("midrst_busy",   32'(bus4.busy), 32'h0);
        check("midrst_wrap",   32'(bus4.wrap), 32'h0);
        rst = 1'b0;
        step();
        check("rerun_clkout", 32'(bus4.CLKout), 32'h1);
        check("rerun_busy",   32'(bus4.busy), 32'h1);

        // 6-phase two-hot, div=2
        do_reset();
        bus6.div   = 8'd2;
        bus6.mode  = 1'b1;
        bus6.start = 1'b1;
        step();
        for (int k = 0; k < 21; k++) begin
            if (k > 0) step();
            check("rot6_clkout", 32'(bus6.CLKout), 32'(tbl6[(k / 3) % 6]));
            check("rot6_wrap",   32'(bus6.wrap), (k == 18) ? 32'h1 : 32'h0);
        end

        // div all-ones: phase 0 lasts 256 cycles
        do_reset();
        bus6.div   = 8'hFF;
        bus6.mode  = 1'b0;
        bus6.start = 1'b1;
        step();
        n = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus6.phase_idx != 3'd0) break;
            n++;
        end
        check("maxdiv_dwell",  32'(n), 32'd256);
        check("maxdiv_idx",    32'(bus6.phase_idx), 32'h1);
        check("maxdiv_clkout", 32'(bus6.CLKout), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
